instr_encoder: RTL and testbench

- Builds 32-bit ARM instruction words (data-processing, memory, branch) from field inputs. It is the encoding counterpart of the control decoder.
- Feeds the instruction-memory loader and the core testbench via a valid/ready stream.
- Checks each request against the subset the core decodes, buffers legal words in a small FIFO and tags each with its program address.
- Illegal requests are counted and dropped.

---
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: builds 32-bit ARM instruction words (DP, MEM, BRANCH) from
// field inputs and streams legal words out through a small FIFO.
// Ports:
//   clk, reset (sync, active-low), flush (sync clear of FIFO and address)
//   in_valid/in_ready + op, cond, funct, rn, rd, src2, imm24 : request stream
//   out_valid/out_ready + out_instr, out_addr : encoded word stream
//   err_pulse, err_count : illegal-request reporting
//   word_count : words accepted into the FIFO (wraps)
module instr_encoder #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [3:0]  cond,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] imm24,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic [15:0] word_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [31:0]   next_addr;
    logic [31:0]   word;
    logic          illegal;
    logic          accept;
    logic          push;
    logic          pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~illegal & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        illegal = 1'b0;
        if (op == 2'b11)
            illegal = 1'b1;
        else if (op == 2'b10 && !funct[5])
            illegal = 1'b1;
        else if (op == 2'b00 && funct[4:3] == 2'b10 && !funct[0])
            illegal = 1'b1;
        else if (op == 2'b01 && funct[2])
            illegal = 1'b1;
    end

    always_comb begin
        if (op == 2'b10)
            word = {cond, 2'b10, funct[5:4], imm24};
        else
            word = {cond, op, funct, rn, rd, src2};
    end

    always_comb begin
        rd_next    = rd_ptr + AW'(pop);
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_instr[wr_ptr] <= word;
            mem_addr[wr_ptr]  <= next_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            next_addr  <= BASE_ADDR;
            out_instr  <= '0;
            out_addr   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            err_pulse <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                next_addr  <= next_addr + 32'd4;
                word_count <= word_count + 16'd1;
            end
            rd_ptr    <= rd_next;
            count     <= count_next;
            err_pulse <= accept & illegal;
            if (accept && illegal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            // Head registers: take the new word directly when it lands in an
            // empty slot at the head; hold the last value when draining empty.
            if (count_next != '0) begin
                if (push && rd_next == wr_ptr) begin
                    out_instr <= word;
                    out_addr  <= next_addr;
                end else begin
                    out_instr <= mem_instr[rd_next];
                    out_addr  <= mem_addr[rd_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven encode checks plus directed sequences for
// backpressure, illegal requests, flush, reset and error saturation.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = '0;
    logic [3:0]  cond = '0;
    logic [5:0]  funct = '0;
    logic [3:0]  rn = '0;
    logic [3:0]  rd = '0;
    logic [11:0] src2 = '0;
    logic [23:0] imm24 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] word_count;

    instr_encoder #(.DEPTH(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cond(cond), .funct(funct), .rn(rn), .rd(rd),
        .src2(src2), .imm24(imm24),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_count(err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  cond;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
        logic        bad;
        logic [31:0] instr;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_wc;
    logic [7:0]  exp_ec;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put(input vec_t v);
        op = v.op; cond = v.cond; funct = v.funct;
        rn = v.rn; rd = v.rd; src2 = v.src2; imm24 = v.imm24;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        //           op     cond   funct       rn    rd    src2    imm24       bad   instr
        vt[0]  = '{2'b00, 4'hE, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0,      1'b0, 32'hE2812005};
        vt[1]  = '{2'b10, 4'hE, 6'b100000, 4'h0, 4'h0, 12'h000, 24'hFFFFFD, 1'b0, 32'hEAFFFFFD};
        vt[2]  = '{2'b01, 4'hE, 6'b011001, 4'h3, 4'h4, 12'h010, 24'h0,      1'b0, 32'hE5934010};
        vt[3]  = '{2'b00, 4'h0, 6'b010101, 4'h5, 4'h0, 12'h006, 24'h0,      1'b0, 32'h01550006};
        vt[4]  = '{2'b00, 4'hE, 6'b010100, 4'h5, 4'h0, 12'h006, 24'h0,      1'b1, 32'h0};
        vt[5]  = '{2'b11, 4'hE, 6'b000000, 4'h1, 4'h1, 12'h001, 24'h0,      1'b1, 32'h0};
        vt[6]  = '{2'b01, 4'hE, 6'b011100, 4'h2, 4'h3, 12'h004, 24'h0,      1'b1, 32'h0};
        vt[7]  = '{2'b10, 4'hE, 6'b000000, 4'h0, 4'h0, 12'h000, 24'h000001, 1'b1, 32'h0};
        vt[8]  = '{2'b10, 4'hB, 6'b110000, 4'h0, 4'h0, 12'h000, 24'h000010, 1'b0, 32'hBB000010};
        vt[9]  = '{2'b00, 4'hF, 6'b011001, 4'hA, 4'hB, 12'hFFF, 24'h0,      1'b0, 32'hF19ABFFF};
        vt[10] = '{2'b00, 4'hE, 6'b010000, 4'h1, 4'h0, 12'h0FF, 24'h0,      1'b1, 32'h0};
        vt[11] = '{2'b00, 4'hE, 6'b010001, 4'h1, 4'h0, 12'h0FF, 24'h0,      1'b0, 32'hE11100FF};
        vt[12] = '{2'b01, 4'hE, 6'b010000, 4'h2, 4'h3, 12'h004, 24'h0,      1'b0, 32'hE5023004};

        exp_addr = BASE;
        exp_wc   = '0;
        exp_ec   = '0;

        // reset state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // backpressure: two accepted, third held until a slot frees
        out_ready = 1'b0;
        put(vt[0]);
        @(negedge clk);
        put(vt[1]);
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 0);
        chk("bp_head0_instr", out_instr, vt[0].instr);
        chk("bp_head0_addr", out_addr, BASE);
        put(vt[2]);
        repeat (2) @(negedge clk);
        chk("bp_hold_ready", 32'(in_ready), 0);
        chk("bp_hold_wc", 32'(word_count), 2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head1_instr", out_instr, vt[1].instr);
        chk("bp_head1_addr", out_addr, BASE + 32'd4);
        chk("bp_slot_ready", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        chk("bp_head2_instr", out_instr, vt[2].instr);
        chk("bp_head2_addr", out_addr, BASE + 32'd8);
        chk("bp_wc3", 32'(word_count), 3);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 0);
        exp_addr = BASE + 32'd12;
        exp_wc   = 16'd3;

        // table of single encodes, streamed back to back with out_ready=1
        for (int i = 0; i < NV; i++) begin
            put(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d_err_pulse", i), 32'(err_pulse), 32'(vt[i].bad));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(!vt[i].bad));
            if (vt[i].bad) begin
                exp_ec++;
            end else begin
                chk($sformatf("v%0d_instr", i), out_instr, vt[i].instr);
                chk($sformatf("v%0d_addr", i), out_addr, exp_addr);
                exp_addr += 32'd4;
                exp_wc++;
            end
        end
        idle();
        @(negedge clk);
        chk("tbl_err_count", 32'(err_count), 32'(exp_ec));
        chk("tbl_word_count", 32'(word_count), 32'(exp_wc));
        chk("tbl_pulse_clear", 32'(err_pulse), 0);

        // illegal set back to back: nothing reaches the FIFO
        put(vt[4]);
        @(negedge clk);
        chk("ill_cmp_pulse", 32'(err_pulse), 1);
        chk("ill_cmp_valid", 32'(out_valid), 0);
        put(vt[5]);
        @(negedge clk);
        chk("ill_op11_pulse", 32'(err_pulse), 1);
        chk("ill_op11_valid", 32'(out_valid), 0);
        put(vt[6]);
        @(negedge clk);
        chk("ill_strb_pulse", 32'(err_pulse), 1);
        chk("ill_strb_valid", 32'(out_valid), 0);
        idle();
        exp_ec += 8'd3;
        @(negedge clk);
        chk("ill_err_count", 32'(err_count), 32'(exp_ec));
        chk("ill_word_count", 32'(word_count), 32'(exp_wc));
        put(vt[0]);
        @(negedge clk);
        idle();
        chk("ill_addr_kept", out_addr, exp_addr);
        exp_addr += 32'd4;
        exp_wc++;
        @(negedge clk);

        // flush with two words buffered and a legal request present
        out_ready = 1'b0;
        put(vt[1]);
        @(negedge clk);
        put(vt[2]);
        @(negedge clk);
        exp_wc += 16'd2;
        chk("fl_pre_valid", 32'(out_valid), 1);
        put(vt[3]);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl_empty", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);
        chk("fl_wc", 32'(word_count), 32'(exp_wc));
        chk("fl_ec", 32'(err_count), 32'(exp_ec));
        chk("fl_no_pulse", 32'(err_pulse), 0);
        out_ready = 1'b1;
        put(vt[8]);
        @(negedge clk);
        idle();
        chk("fl_next_addr", out_addr, BASE);
        chk("fl_next_instr", out_instr, vt[8].instr);
        @(negedge clk);

        // reset mid-stream with the FIFO full
        out_ready = 1'b0;
        put(vt[0]);
        @(negedge clk);
        put(vt[9]);
        @(negedge clk);
        idle();
        chk("mr_full", 32'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_instr", out_instr, 0);
        chk("mr_addr", out_addr, 0);
        chk("mr_wc", 32'(word_count), 0);
        chk("mr_ec", 32'(err_count), 0);
        chk("mr_ready", 32'(in_ready), 1);

        // 300 illegal requests: err_count saturates
        out_ready = 1'b1;
        put(vt[5]);
        for (int i = 0; i < 300; i++) @(negedge clk);
        idle();
        chk("sat_err_count", 32'(err_count), 255);
        chk("sat_pulse", 32'(err_pulse), 1);
        @(negedge clk);
        chk("sat_hold", 32'(err_count), 255);
        chk("sat_wc", 32'(word_count), 0);
        chk("sat_valid", 32'(out_valid), 0);
        put(vt[11]);
        @(negedge clk);
        idle();
        chk("sat_post_addr", out_addr, BASE);
        chk("sat_post_instr", out_instr, vt[11].instr);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
